// File: rtl/hp_wind_ctl_pkg.sv
// Shared types and constants for the HP-bar / wind game-state block.
package hp_wind_ctl_pkg;

    localparam int HP_MAX_DEF   = 100;
    localparam int WIND_MAG_MAX = 3;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;
    localparam logic [1:0] WINNER_DRAW = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_OVER  = 2'd2
    } drain_state_t;

    // HP never wraps below zero: overkill damage simply empties the bar.
    function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? (a - b) : 7'd0;
    endfunction

endpackage

// File: rtl/hp_wind_ctl_if.sv
// Event strobes from game logic and registered status toward the HP/wind drawing stage.
interface hp_wind_ctl_if;
    import hp_wind_ctl_pkg::*;

    // Handshake: every event input is a 1-cycle strobe (valid) that the block
    // always accepts in the cycle it is high (ready is implicitly 1); dmg_pX is
    // only meaningful while its hit_pX is high. Status outputs are level signals.
    logic         new_game;
    logic         hit_p1;
    logic [6:0]   dmg_p1;
    logic         hit_p2;
    logic [6:0]   dmg_p2;
    logic         turn_end;

    logic [6:0]   hp_player1;
    logic [6:0]   hp_player2;
    logic [2:0]   wind;
    logic         draining;
    logic         game_over;
    logic [1:0]   winner;
    drain_state_t drain_state;

    modport master (
        output new_game, hit_p1, dmg_p1, hit_p2, dmg_p2, turn_end,
        input  hp_player1, hp_player2, wind, draining, game_over, winner, drain_state
    );

    modport slave (
        input  new_game, hit_p1, dmg_p1, hit_p2, dmg_p2, turn_end,
        output hp_player1, hp_player2, wind, draining, game_over, winner, drain_state
    );

endinterface

// File: rtl/hp_wind_ctl_wind_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the wind source.
module hp_wind_ctl_wind_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk60MHz,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk60MHz) begin
        if (rst) state <= SEED;
        else     state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
    end

endmodule

// File: rtl/hp_wind_ctl.sv
// Owns both players' HP targets and displayed HP, drains the display toward the
// target, draws wind on turn end and reports game over / winner.
module hp_wind_ctl
    import hp_wind_ctl_pkg::*;
#(
    parameter int          HP_MAX    = HP_MAX_DEF,
    parameter int          DRAIN_DIV = 600_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk60MHz,
    input  logic           rst,
    hp_wind_ctl_if.slave   bus
);

    localparam int               CNT_W    = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_DIV - 1);
    localparam logic [6:0]       HP_FULL  = 7'(HP_MAX);

    drain_state_t     state, state_n;
    logic [6:0]       hp1, hp2, tgt1, tgt2;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       wind_q;
    logic [1:0]       winner_q, winner_n;
    logic [15:0]      lfsr;
    logic             step;
    logic             unused_lfsr_hi;

    hp_wind_ctl_wind_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk60MHz (clk60MHz),
        .rst      (rst),
        .state    (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:3];

    always_ff @(posedge clk60MHz) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        winner_n = WINNER_NONE;
        unique case (state)
            S_IDLE:  if (hp1 != tgt1 || hp2 != tgt2) state_n = S_DRAIN;
            S_DRAIN: begin
                if (hp1 == 7'd0 || hp2 == 7'd0)      state_n = S_OVER;
                else if (hp1 == tgt1 && hp2 == tgt2) state_n = S_IDLE;
            end
            S_OVER:  state_n = S_OVER;
            default: state_n = S_IDLE;
        endcase
        if (bus.new_game) state_n = S_IDLE;

        if (hp1 == 7'd0 && hp2 == 7'd0) winner_n = WINNER_DRAW;
        else if (hp1 == 7'd0)           winner_n = WINNER_P2;
        else                            winner_n = WINNER_P1;
    end

    // No drain step on the cycle we leave DRAIN, so the winner is judged on the
    // same HP values that stay frozen on screen.
    assign step = (state == S_DRAIN) && (state_n == S_DRAIN) && (cnt == CNT_LAST);

    always_ff @(posedge clk60MHz) begin
        if (rst || bus.new_game) begin
            hp1      <= HP_FULL;
            hp2      <= HP_FULL;
            tgt1     <= HP_FULL;
            tgt2     <= HP_FULL;
            cnt      <= '0;
            wind_q   <= 3'd0;
            winner_q <= WINNER_NONE;
        end else begin
            if (bus.hit_p1 && state != S_OVER) tgt1 <= sat_sub(tgt1, bus.dmg_p1);
            if (bus.hit_p2 && state != S_OVER) tgt2 <= sat_sub(tgt2, bus.dmg_p2);

            if (state == S_DRAIN && state_n == S_DRAIN)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            else
                cnt <= '0;

            if (step && hp1 > tgt1) hp1 <= hp1 - 7'd1;
            if (step && hp2 > tgt2) hp2 <= hp2 - 7'd1;

            // Zero magnitude always shows as "right" so a "-0" never appears.
            if (bus.turn_end && state != S_OVER)
                wind_q <= {(lfsr[1:0] != 2'd0) & lfsr[2], lfsr[1:0]};

            if (state != S_OVER && state_n == S_OVER) winner_q <= winner_n;
        end
    end

    assign bus.hp_player1  = hp1;
    assign bus.hp_player2  = hp2;
    assign bus.wind        = wind_q;
    assign bus.draining    = (state == S_DRAIN);
    assign bus.game_over   = (state == S_OVER);
    assign bus.winner      = winner_q;
    assign bus.drain_state = state;

endmodule

// File: tb/tb_hp_wind_ctl.sv
// Directed bench for hp_wind_ctl: vector table for drain outcomes plus hand sequences.
module tb_hp_wind_ctl;
    import hp_wind_ctl_pkg::*;

    localparam int DIV = 4;

    logic clk60MHz = 1'b0;
    logic rst      = 1'b1;

    always #5 clk60MHz = ~clk60MHz;

    hp_wind_ctl_if bus();

    hp_wind_ctl #(.HP_MAX(100), .DRAIN_DIV(DIV), .LFSR_SEED(16'hACE1)) dut (
        .clk60MHz (clk60MHz),
        .rst      (rst),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right.
    logic [15:0] m_lfsr;
    always @(posedge clk60MHz) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    logic [2:0] exp_q[$];

    typedef struct {
        logic       h1;
        logic [6:0] d1;
        logic       h2;
        logic [6:0] d2;
        logic [6:0] e_hp1;
        logic [6:0] e_hp2;
        logic       e_over;
        logic [1:0] e_win;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk60MHz);
        #1;
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1;
        cyc();
        bus.new_game = 1'b0;
    endtask

    task automatic hit(input logic h1, input logic [6:0] d1, input logic h2, input logic [6:0] d2);
        bus.hit_p1 = h1; bus.dmg_p1 = d1;
        bus.hit_p2 = h2; bus.dmg_p2 = d2;
        cyc();
        bus.hit_p1 = 1'b0; bus.dmg_p1 = 7'd0;
        bus.hit_p2 = 1'b0; bus.dmg_p2 = 7'd0;
    endtask

    function automatic logic [2:0] wind_model(input logic [15:0] s);
        logic [1:0] mag;
        mag = s[1:0];
        return {(mag == 2'd0) ? 1'b0 : s[2], mag};
    endfunction

    task automatic turn();
        exp_q.push_back(wind_model(m_lfsr));
        bus.turn_end = 1'b1;
        cyc();
        bus.turn_end = 1'b0;
        check("wind_value", bus.wind, exp_q.pop_front());
        check("wind_no_neg_zero", bus.wind == 3'b100, 0);
    endtask

    initial begin
        int k;
        int mism;
        logic [2:0] w_hold;

        bus.new_game = 1'b0; bus.turn_end = 1'b0;
        bus.hit_p1 = 1'b0; bus.dmg_p1 = 7'd0;
        bus.hit_p2 = 1'b0; bus.dmg_p2 = 7'd0;

        //              h1   d1       h2   d2       hp1      hp2      over  win
        vecs[0] = '{1'b1, 7'd30,  1'b0, 7'd0,   7'd70,  7'd100, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 7'd0,   1'b1, 7'd120, 7'd100, 7'd0,   1'b1, 2'd1};
        vecs[2] = '{1'b1, 7'd100, 1'b1, 7'd100, 7'd0,   7'd0,   1'b1, 2'd3};
        vecs[3] = '{1'b1, 7'd127, 1'b0, 7'd0,   7'd0,   7'd100, 1'b1, 2'd2};
        vecs[4] = '{1'b1, 7'd5,   1'b1, 7'd7,   7'd95,  7'd93,  1'b0, 2'd0};
        vecs[5] = '{1'b0, 7'd0,   1'b1, 7'd99,  7'd100, 7'd1,   1'b0, 2'd0};
        vecs[6] = '{1'b1, 7'd0,   1'b0, 7'd0,   7'd100, 7'd100, 1'b0, 2'd0};

        // Reset
        #1;
        cyc(); cyc();
        check("rst_hp1", bus.hp_player1, 100);
        check("rst_hp2", bus.hp_player2, 100);
        check("rst_wind", bus.wind, 0);
        check("rst_game_over", bus.game_over, 0);
        check("rst_winner", bus.winner, 0);
        check("rst_draining", bus.draining, 0);
        check("rst_state", bus.drain_state, S_IDLE);
        rst = 1'b0;
        cyc();

        // Single hit with drain timing
        hit(1'b1, 7'd30, 1'b0, 7'd0);
        k = 0;
        while (k < 200 && bus.hp_player1 != 7'd70) begin
            cyc();
            k++;
            if (k == 1) check("single_draining_rise", bus.draining, 1);
            if (k == DIV) check("single_hold_before_step", bus.hp_player1, 100);
            if (k == DIV + 1) check("single_first_step", bus.hp_player1, 99);
        end
        check("single_reach_70", bus.hp_player1, 70);
        check("single_latency_window", (k >= 30 * DIV - 1) && (k <= 30 * DIV + 1), 1);
        cyc();
        check("single_draining_fall", bus.draining, 0);
        check("single_hp2_untouched", bus.hp_player2, 100);

        // Table-driven outcomes
        for (int i = 0; i < 7; i++) begin
            pulse_new_game();
            hit(vecs[i].h1, vecs[i].d1, vecs[i].h2, vecs[i].d2);
            repeat (100 * DIV + 30) cyc();
            check($sformatf("vec%0d_hp1", i), bus.hp_player1, vecs[i].e_hp1);
            check($sformatf("vec%0d_hp2", i), bus.hp_player2, vecs[i].e_hp2);
            check($sformatf("vec%0d_over", i), bus.game_over, vecs[i].e_over);
            check($sformatf("vec%0d_winner", i), bus.winner, vecs[i].e_win);
            check($sformatf("vec%0d_draining", i), bus.draining, 0);
            if (vecs[i].e_over) begin
                hit(1'b1, 7'd10, 1'b1, 7'd10);
                repeat (10 * DIV + 10) cyc();
                check($sformatf("vec%0d_hit_ignored_hp1", i), bus.hp_player1, vecs[i].e_hp1);
                check($sformatf("vec%0d_hit_ignored_hp2", i), bus.hp_player2, vecs[i].e_hp2);
            end
        end

        // Saturating kill: game_over lands one cycle after hp reaches 0
        pulse_new_game();
        turn();
        hit(1'b0, 7'd0, 1'b1, 7'd120);
        k = 0;
        while (k < 500 && bus.hp_player2 != 7'd0) begin
            cyc();
            k++;
        end
        check("kill_hp2_zero", bus.hp_player2, 0);
        check("kill_over_not_yet", bus.game_over, 0);
        cyc();
        check("kill_over_set", bus.game_over, 1);
        check("kill_winner", bus.winner, 1);
        w_hold = bus.wind;
        bus.turn_end = 1'b1;
        cyc();
        bus.turn_end = 1'b0;
        check("over_wind_hold", bus.wind, w_hold);
        hit(1'b1, 7'd10, 1'b0, 7'd0);
        repeat (20) cyc();
        check("over_hp1_hold", bus.hp_player1, 100);

        // Simultaneous hits drain in lockstep
        pulse_new_game();
        hit(1'b1, 7'd100, 1'b1, 7'd100);
        mism = 0;
        k = 0;
        while (k < 500 && !bus.game_over) begin
            cyc();
            k++;
            if (bus.hp_player1 != bus.hp_player2) mism++;
        end
        check("lockstep_mismatches", mism, 0);
        check("lockstep_over", bus.game_over, 1);
        check("lockstep_winner", bus.winner, 3);

        // Wind sequence against the reference LFSR
        pulse_new_game();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) cyc();
            turn();
        end

        // new_game mid-drain, with a simultaneous turn_end
        k = 0;
        while (k < 10 && bus.wind == 3'd0) begin
            turn();
            k++;
        end
        check("prep_wind_nonzero", bus.wind != 3'd0, 1);
        hit(1'b1, 7'd60, 1'b0, 7'd0);
        k = 0;
        while (k < 300 && bus.hp_player1 != 7'd85) begin
            cyc();
            k++;
        end
        check("mid_hp1_85", bus.hp_player1, 85);
        bus.new_game = 1'b1;
        bus.turn_end = 1'b1;
        cyc();
        bus.new_game = 1'b0;
        bus.turn_end = 1'b0;
        check("ng_hp1", bus.hp_player1, 100);
        check("ng_hp2", bus.hp_player2, 100);
        check("ng_draining", bus.draining, 0);
        check("ng_wind", bus.wind, 0);
        check("ng_game_over", bus.game_over, 0);
        repeat (3 * DIV) cyc();
        check("ng_target_restored", bus.hp_player1, 100);
        check("ng_still_idle", bus.draining, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
